// File: rtl/cdc_fifo_wr_packer_if.sv
// Nibble-producer / CDC-FIFO write-side bundle for cdc_fifo_wr_packer.
// The master modport is the producer/FIFO side. The slave modport is the packer.
interface cdc_fifo_wr_packer_if;
   logic [3:0] nib_in;
   logic       nib_valid;
   logic       nib_ready;
   logic       flush;
   logic       fifo_full;
   logic       fifo_wr_en;
   logic [7:0] fifo_wr_data;
   logic       fifo_wr_par;
   logic [7:0] word_cnt;
   logic       busy;

   modport master (
      output nib_in, nib_valid, flush, fifo_full,
      input  nib_ready, fifo_wr_en, fifo_wr_data, fifo_wr_par, word_cnt, busy
   );

   modport slave (
      input  nib_in, nib_valid, flush, fifo_full,
      output nib_ready, fifo_wr_en, fifo_wr_data, fifo_wr_par, word_cnt, busy
   );
endinterface

// File: rtl/cdc_fifo_wr_packer.sv
// cdc_fifo_wr_packer: packs pairs of 4-bit nibbles into bytes and writes them
// into the write side of a CDC FIFO. The first nibble goes into the low half.
// A flush pads a half-filled word with PAD_NIBBLE.
// Optional feature: define PACKER_PARITY_EN to drive even parity on fifo_wr_par.
module cdc_fifo_wr_packer #(
   parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   cdc_fifo_wr_packer_if.slave     bus
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_PUSH  = 2'd2
   } state_t;

   state_t     r_state;
   logic [7:0] r_word;
   logic [7:0] r_word_cnt;

   logic       w_nib_ready;
   logic       w_wr_en;
   logic       w_xfer;

   // A full word blocks new nibbles only while the FIFO cannot take it.
   // A nibble can therefore land in the same cycle that the word drains.
   assign w_nib_ready = (r_state != S_PUSH) | ~bus.fifo_full;
   assign w_wr_en     = (r_state == S_PUSH) & ~bus.fifo_full;
   assign w_xfer      = bus.nib_valid & w_nib_ready;

   // Packing FSM: the hold register, the state and the write counter all advance together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_EMPTY;
         r_word     <= 8'h00;
         r_word_cnt <= 8'h00;
      end else begin
         case (r_state)
            S_EMPTY: begin
               // flush has no effect here: there is nothing to pad
               if (w_xfer) begin
                  r_word[3:0] <= bus.nib_in;
                  r_state     <= S_HALF;
               end
            end
            S_HALF: begin
               // a real nibble wins over a simultaneous flush
               if (w_xfer) begin
                  r_word[7:4] <= bus.nib_in;
                  r_state     <= S_PUSH;
               end else if (bus.flush) begin
                  r_word[7:4] <= PAD_NIBBLE;
                  r_state     <= S_PUSH;
               end
            end
            S_PUSH: begin
               // word held untouched until the FIFO accepts it
               if (w_wr_en) begin
                  r_word_cnt <= r_word_cnt + 8'd1;
                  if (w_xfer) begin
                     r_word[3:0] <= bus.nib_in;
                     r_state     <= S_HALF;
                  end else begin
                     r_state     <= S_EMPTY;
                  end
               end
            end
            default: begin
               r_state <= S_EMPTY;
            end
         endcase
      end
   end

   assign bus.nib_ready    = w_nib_ready;
   assign bus.fifo_wr_en   = w_wr_en;
   assign bus.fifo_wr_data = r_word;
   assign bus.word_cnt     = r_word_cnt;
   assign bus.busy         = (r_state != S_EMPTY);

`ifdef PACKER_PARITY_EN
   assign bus.fifo_wr_par  = ^r_word;
`else
   assign bus.fifo_wr_par  = 1'b0;
`endif

endmodule

// File: doc/cdc_fifo_wr_packer.md
CDC_FIFO_WR_PACKER -- requirements
Module: cdc_fifo_wr_packer

Interface
REQ-001 SHALL have parameter PAD_NIBBLE, default 4'h0: upper-nibble fill value on flush.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port nib_in  input  4  nibble data from the producer.
REQ-005 SHALL have port nib_valid  input  1  nib_in valid.
REQ-006 SHALL have port nib_ready  output  1  packer can accept a nibble this cycle.
REQ-007 SHALL have port flush  input  1  push a half-filled word, padded.
REQ-008 SHALL have port fifo_full  input  1  full flag from the downstream CDC FIFO write side.
REQ-009 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-010 SHALL have port fifo_wr_data  output  8  FIFO write data.
REQ-011 SHALL have port fifo_wr_par  output  1  parity of fifo_wr_data (see Configuration).
REQ-012 SHALL have port word_cnt  output  8  count of words written to the FIFO.
REQ-013 SHALL have port busy  output  1  high when state is not EMPTY.

Function
REQ-014 SHALL implement the states EMPTY, HALF and PUSH in a state register.
REQ-015 SHALL complete a nibble transfer on any rising edge where nib_valid and nib_ready are both high.
REQ-016 SHALL drive nib_ready = (state!=PUSH) | ~fifo_full.
REQ-017 SHALL store an accepted nibble as word[3:0] in EMPTY and go to HALF.
REQ-018 SHALL store an accepted nibble as word[7:4] in HALF and go to PUSH.
REQ-019 SHALL, in HALF with flush=1 and no transfer, set word[7:4]=PAD_NIBBLE and go to PUSH.
REQ-020 SHALL give a nibble transfer priority over flush in HALF; flush is ignored that cycle.
REQ-021 SHALL ignore flush in EMPTY and PUSH.
REQ-022 SHALL drive fifo_wr_en = (state==PUSH) & ~fifo_full, combinationally.
REQ-023 SHALL drive fifo_wr_data from the hold register; its value is stable for the whole PUSH state.
REQ-024 SHALL remain in PUSH while fifo_full=1, with the word held and no loss.
REQ-025 SHALL, in PUSH with fifo_wr_en=1 and a simultaneous nibble transfer, store that nibble as the new word[3:0] and go to HALF in the same edge.
REQ-026 SHALL, in PUSH with fifo_wr_en=1 and no transfer, go to EMPTY.
REQ-027 SHALL assert fifo_wr_en in the cycle following the second-nibble transfer when fifo_full=0; latency is 1 cycle.
REQ-028 SHALL increment word_cnt by 1 modulo 256 on each edge where fifo_wr_en=1; the count wraps from 255 to 0.
REQ-029 SHALL sustain one FIFO write per two cycles with continuous nib_valid and fifo_full=0.

Reset
REQ-030 SHALL, while rst=1, immediately force the following: state=EMPTY, hold register=8'h00, word_cnt=0.
REQ-031 SHALL, while rst=1, hold the outputs at busy=0, fifo_wr_en=0, fifo_wr_data=8'h00, fifo_wr_par=0 and nib_ready=1.
REQ-032 SHALL discard a partial or pending word on reset mid-operation, with no FIFO write and no count change.

Configuration
REQ-033 SHALL, with PACKER_PARITY_EN defined, drive fifo_wr_par = XOR of fifo_wr_data[7:0] (even parity).
REQ-034 SHALL, without PACKER_PARITY_EN, tie fifo_wr_par to 0 and contain no parity logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover basic packing: nibbles 4'h5 then 4'hA, fifo_full=0 -> one cycle of fifo_wr_en with data 8'hA5; word_cnt=1; busy returns to 0.
REQ-036 SHALL cover backpressure: hold fifo_full=1 for 5 cycles after the word 8'h3C is formed -> fifo_wr_en=0 and nib_ready=0 throughout; data stays 8'h3C; a single write occurs after fifo_full falls.
REQ-037 SHALL cover flush: nibble 4'h7, then flush, with PAD_NIBBLE=4'h0 -> write of 8'h07; flush in EMPTY -> no write.
REQ-038 SHALL cover simultaneous events: in PUSH with fifo_full=0, present nibble 4'h9 -> the write occurs and the state is HALF with word[3:0]=9; in HALF, nib_valid and flush together -> a normal nibble, not a pad.
REQ-039 SHALL cover wrap and reset: 256 writes -> word_cnt=0; rst pulsed in HALF -> busy=0 and no write ever occurs for the partial word.
REQ-040 SHALL cover parity, with PACKER_PARITY_EN defined: word 8'h07 -> fifo_wr_par=1; word 8'hA5 -> fifo_wr_par=0.
